// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for pipelined_addsub: operand side (in_*) and result side (out_*).
// The master drives operands and out_ready; the slave (the adder) drives everything else.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Two's-complement add/sub with the WIDTH-bit carry chain cut into STAGES registered
// segments; per-stage valids form an elastic pipeline with a full-throughput ready chain.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus
);
  localparam int SEG = WIDTH / ((STAGES < 1) ? 1 : STAGES);

  if (STAGES < 1 || (WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: STAGES must be >= 1 and divide WIDTH");
  end

  // b is inverted once at entry, so later stages only need the carry, not the mode.
  logic             sub_s;
  logic [WIDTH-1:0] b_eff_s;
  assign sub_s   = ~bus.mode;
  assign b_eff_s = bus.b ^ {WIDTH{sub_s}};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int DONE = (s + 1) * SEG;
    localparam int REM  = WIDTH - DONE;

    logic            v_q;
    logic            en_s;
    logic            load_s;
    logic            valid_in_s;
    logic            cin_s;
    logic [SEG-1:0]  a_seg_s;
    logic [SEG-1:0]  b_seg_s;
    logic [SEG:0]    add_s;
    logic [DONE-1:0] sum_d;
    logic [DONE-1:0] sum_q;
    logic            cy_q;

    if (s == 0) begin : g_head
      assign valid_in_s = bus.in_valid;
      assign a_seg_s    = bus.a[SEG-1:0];
      assign b_seg_s    = b_eff_s[SEG-1:0];
      assign cin_s      = sub_s;
      assign sum_d      = add_s[SEG-1:0];
    end else begin : g_body
      assign valid_in_s = g_stage[s-1].v_q;
      assign a_seg_s    = g_stage[s-1].g_skew.a_q[SEG-1:0];
      assign b_seg_s    = g_stage[s-1].g_skew.b_q[SEG-1:0];
      assign cin_s      = g_stage[s-1].cy_q;
      assign sum_d      = {add_s[SEG-1:0], g_stage[s-1].sum_q};
    end

    assign add_s  = {1'b0, a_seg_s} + {1'b0, b_seg_s} + {{SEG{1'b0}}, cin_s};
    assign load_s = en_s & valid_in_s;

    if (s == STAGES - 1) begin : g_tail
      logic ovf_q;
      assign en_s = ~v_q | bus.out_ready;

      // Carry into the MSB is recovered from the MSB sum bit; overflow compares it with carry out.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (load_s) begin
          ovf_q <= (sum_d[WIDTH-1] ^ a_seg_s[SEG-1] ^ b_seg_s[SEG-1]) ^ add_s[SEG];
        end
      end
    end else begin : g_mid
      assign en_s = ~v_q | g_stage[s+1].en_s;
    end

    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (s == 0) begin : g_from_bus
        assign a_d = bus.a[WIDTH-1:SEG];
        assign b_d = b_eff_s[WIDTH-1:SEG];
      end else begin : g_from_prev
        assign a_d = g_stage[s-1].g_skew.a_q[REM+SEG-1:SEG];
        assign b_d = g_stage[s-1].g_skew.b_q[REM+SEG-1:SEG];
      end

      // Operand bits not yet consumed travel alongside their partial result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load_s) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Valid moves on every enable; data only moves with a real operation so idle outputs hold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        cy_q  <= 1'b0;
      end else begin
        if (en_s) begin
          v_q <= valid_in_s;
        end
        if (load_s) begin
          sum_q <= sum_d;
          cy_q  <= add_s[SEG];
        end
      end
    end
  end

  assign bus.in_ready  = ~rst & g_stage[0].en_s;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].sum_q;
  assign bus.c_out     = g_stage[STAGES-1].cy_q;
  assign bus.overflow  = g_stage[STAGES-1].g_tail.ovf_q;
endmodule
